// File: rtl/no_space_ctrl.sv
// No-space error aggregator: edge-detects per-source errors, arbitrates them
// round-robin into single-cycle increment strobes, and keeps a saturating count.
module no_space_ctrl #(
  parameter int N_SRC = 4,
  parameter int CTR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SRC-1:0]           no_space_err,
  input  logic                       clr_ctr,
  input  logic [CTR_W-1:0]           thresh,
  output logic                       no_space_ctr_incr,
  output logic [$clog2(N_SRC)-1:0]   incr_src,
  output logic [CTR_W-1:0]           no_space_ctr,
  output logic [N_SRC-1:0]           pend,
  output logic                       thresh_irq,
  output logic                       drop_err
);

  localparam int IW = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic             incr_q, incr_d;
  logic [IW-1:0]    src_q, src_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             irq_q, irq_d;
  logic             drop_q, drop_d;

  logic [N_SRC-1:0] evt, req, gmask;
  logic             grant, dropped, inc;
  logic [IW-1:0]    gidx, cand;

  always_comb begin
    evt   = no_space_err & ~prev_q;
    req   = pend_q | evt;
    grant = 1'b0;
    gidx  = '0;
    cand  = '0;
    gmask = '0;
    // Round-robin search starting at ptr; only an IDLE FSM can accept a grant.
    if (state_q == IDLE) begin
      for (int unsigned k = 0; k < N_SRC; k++) begin
        cand = IW'((32'(ptr_q) + k) % N_SRC);
        if (!grant && req[cand]) begin
          grant = 1'b1;
          gidx  = cand;
        end
      end
    end
    if (grant) gmask[gidx] = 1'b1;

    pend_d  = req & ~gmask;
    dropped = |(evt & pend_q & ~gmask);
    ptr_d   = grant ? IW'((32'(gidx) + 1) % N_SRC) : ptr_q;
    incr_d  = grant;
    src_d   = grant ? gidx : '0;

    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = grant ? PULSE : IDLE;
      PULSE:   state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    inc   = (state_q == PULSE);
    ctr_d = ctr_q;
    if (clr_ctr)              ctr_d = inc ? CTR_W'(1) : '0;
    else if (inc && ctr_q != '1) ctr_d = ctr_q + CTR_W'(1);

    // Clear first, then the threshold test sees the freshly updated count.
    irq_d = clr_ctr ? 1'b0 : irq_q;
    if (inc && thresh != '0 && ctr_d >= thresh) irq_d = 1'b1;

    drop_d = (clr_ctr ? 1'b0 : drop_q) | dropped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      incr_q  <= 1'b0;
      src_q   <= '0;
      ctr_q   <= '0;
      irq_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= no_space_err;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      incr_q  <= incr_d;
      src_q   <= src_d;
      ctr_q   <= ctr_d;
      irq_q   <= irq_d;
      drop_q  <= drop_d;
    end
  end

  assign no_space_ctr_incr = incr_q;
  assign incr_src          = src_q;
  assign no_space_ctr      = ctr_q;
  assign pend              = pend_q;
  assign thresh_irq        = irq_q;
  assign drop_err          = drop_q;

endmodule

// File: tb/tb_no_space_ctrl.sv
// Directed bench for no_space_ctrl (N_SRC=4, CTR_W=4) with a per-cycle strobe monitor.
module tb_no_space_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] err = '0;
  logic       clr = 1'b0;
  logic [3:0] thresh = '0;
  logic       incr;
  logic [1:0] src;
  logic [3:0] ctr;
  logic [3:0] pend;
  logic       irq;
  logic       drop;

  int checks = 0;
  int fails  = 0;

  no_space_ctrl #(.N_SRC(4), .CTR_W(4)) dut (
    .clk(clk), .rst(rst), .no_space_err(err), .clr_ctr(clr), .thresh(thresh),
    .no_space_ctr_incr(incr), .incr_src(src), .no_space_ctr(ctr),
    .pend(pend), .thresh_irq(irq), .drop_err(drop)
  );

  always #5 clk = ~clk;

  // Strobe monitor: no back-to-back strobes, and a rise needs a pending/new event.
  logic [3:0] m_prev = '0;
  logic       m_had, m_was;
  always @(posedge rst) m_prev = '0;
  always @(posedge clk) begin
    m_had  = !rst && |(pend | (err & ~m_prev));
    m_was  = incr;
    m_prev = rst ? '0 : err;
    #1;
    if (!rst) begin
      checks++;
      if (m_was && incr) begin
        fails++; $display("FAIL mon_width: incr got 1 want 0 after strobe");
      end
      checks++;
      if (!m_was && incr && !m_had) begin
        fails++; $display("FAIL mon_cause: incr got 1 want 0 with no event");
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; err = '0; clr = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (incr !== 1'b0) begin fails++; $display("FAIL rst_incr: got %0b want 0", incr); end
    checks++; if (ctr  !== 4'd0) begin fails++; $display("FAIL rst_ctr: got %0d want 0", ctr); end
    checks++; if (pend !== 4'd0) begin fails++; $display("FAIL rst_pend: got %0h want 0", pend); end
    checks++; if ({irq, drop, src} !== 4'd0) begin
      fails++; $display("FAIL rst_flags: got %0h want 0", {irq, drop, src});
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({incr, ctr} !== 5'd0) begin fails++; $display("FAIL rst_idle: got %0h want 0", {incr, ctr}); end
  endtask

  task automatic test_single();
    do_reset();
    err = 4'b0001;
    @(negedge clk);
    checks++; if (incr !== 1'b1 || src !== 2'd0) begin
      fails++; $display("FAIL single_strobe: incr/src got %0b/%0d want 1/0", incr, src);
    end
    @(negedge clk);
    checks++; if (incr !== 1'b0 || ctr !== 4'd1) begin
      fails++; $display("FAIL single_after: incr/ctr got %0b/%0d want 0/1", incr, ctr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (incr !== 1'b0 || ctr !== 4'd1) begin
        fails++; $display("FAIL single_hold: incr/ctr got %0b/%0d want 0/1", incr, ctr);
      end
    end
    err = '0;
  endtask

  task automatic test_simultaneous();
    logic       e_incr;
    logic [1:0] e_src;
    logic [3:0] e_pend;
    do_reset();
    err = 4'hF;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e_incr = (k % 3 == 0);
      e_src  = e_incr ? 2'(k / 3) : 2'd0;
      checks++; if (incr !== e_incr || src !== e_src) begin
        fails++; $display("FAIL simul_k%0d: incr/src got %0b/%0d want %0b/%0d", k, incr, src, e_incr, e_src);
      end
      if (e_incr) begin
        e_pend = 4'hE << (k / 3);
        checks++; if (pend !== e_pend) begin
          fails++; $display("FAIL simul_pend_k%0d: got %0h want %0h", k, pend, e_pend);
        end
      end
    end
    checks++; if (ctr !== 4'd4 || pend !== 4'd0) begin
      fails++; $display("FAIL simul_end: ctr/pend got %0d/%0h want 4/0", ctr, pend);
    end
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL simul_thr0: irq got %0b want 0", irq); end
    err = '0;
  endtask

  task automatic test_drop();
    int n1;
    do_reset();
    err = 4'b0011;
    @(negedge clk);
    checks++; if (incr !== 1'b1 || src !== 2'd0 || pend !== 4'b0010) begin
      fails++; $display("FAIL drop_k0: incr/src/pend got %0b/%0d/%0h want 1/0/2", incr, src, pend);
    end
    err = 4'b0001;
    @(negedge clk);
    checks++; if (drop !== 1'b0) begin fails++; $display("FAIL drop_early: got %0b want 0", drop); end
    err = 4'b0011;
    @(negedge clk);
    checks++; if (drop !== 1'b1 || pend !== 4'b0010) begin
      fails++; $display("FAIL drop_set: drop/pend got %0b/%0h want 1/2", drop, pend);
    end
    n1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (incr && src == 2'd1) n1++;
    end
    checks++; if (n1 !== 1) begin fails++; $display("FAIL drop_src1_strobes: got %0d want 1", n1); end
    checks++; if (ctr !== 4'd2 || pend !== 4'd0) begin
      fails++; $display("FAIL drop_end: ctr/pend got %0d/%0h want 2/0", ctr, pend);
    end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (drop !== 1'b0 || ctr !== 4'd0) begin
      fails++; $display("FAIL drop_clr: drop/ctr got %0b/%0d want 0/0", drop, ctr);
    end
    err = '0;
  endtask

  task automatic test_sat_thresh();
    logic [3:0] e_ctr;
    logic       e_irq;
    do_reset();
    thresh = 4'd3;
    for (int e = 0; e < 20; e++) begin
      err = 4'b0001;
      @(negedge clk); err = '0;
      @(negedge clk);
      e_ctr = (e + 1 > 15) ? 4'd15 : 4'(e + 1);
      e_irq = (e + 1 >= 3);
      checks++; if (ctr !== e_ctr || irq !== e_irq) begin
        fails++; $display("FAIL sat_e%0d: ctr/irq got %0d/%0b want %0d/%0b", e, ctr, irq, e_ctr, e_irq);
      end
      @(negedge clk);
    end
    err = 4'b0001;
    @(negedge clk);
    checks++; if (incr !== 1'b1) begin fails++; $display("FAIL clr_pre: incr got %0b want 1", incr); end
    clr = 1'b1; err = '0;
    @(negedge clk); clr = 1'b0;
    checks++; if (ctr !== 4'd1 || irq !== 1'b0) begin
      fails++; $display("FAIL clr_coinc: ctr/irq got %0d/%0b want 1/0", ctr, irq);
    end
    thresh = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    err = 4'b0011;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (incr !== 1'b0 || src !== 2'd0) begin
      fails++; $display("FAIL rmid_incr: incr/src got %0b/%0d want 0/0", incr, src);
    end
    checks++; if (ctr !== 4'd0 || pend !== 4'd0) begin
      fails++; $display("FAIL rmid_state: ctr/pend got %0d/%0h want 0/0", ctr, pend);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++; if (pend !== 4'd0 || ctr !== 4'd0) begin
      fails++; $display("FAIL rmid_release: pend/ctr got %0h/%0d want 0/0", pend, ctr);
    end
    @(negedge clk);
    checks++; if (incr !== 1'b1 || src !== 2'd0 || pend !== 4'b0010) begin
      fails++; $display("FAIL rmid_held_evt: incr/src/pend got %0b/%0d/%0h want 1/0/2", incr, src, pend);
    end
    repeat (3) @(negedge clk);
    checks++; if (incr !== 1'b1 || src !== 2'd1) begin
      fails++; $display("FAIL rmid_second: incr/src got %0b/%0d want 1/1", incr, src);
    end
    @(negedge clk);
    checks++; if (ctr !== 4'd2) begin fails++; $display("FAIL rmid_ctr: got %0d want 2", ctr); end
    err = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_drop();
    test_sat_thresh();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
